// File: rtl/rr_mux.sv
// N-input registered multiplexer with valid/ready on every channel.
// Channel choice is either an external select or a round-robin search starting at ptr.
module rr_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  input  logic                 out_ready
);

  // Handshake: a channel transfers when in_valid[k] && in_ready[k]; the output
  // transfers when out_valid && out_ready. in_ready never looks at in_data.

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gidx;
  logic [SELW-1:0]  cand;
  logic             found;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] gdata;
  logic             space;
  logic             xfer;
  int               s;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    s     = 0;
    if (MODE == 0) begin
      for (int k = 0; k < N; k++) begin
        if (sel == SELW'(k)) begin
          found = in_valid[k];
          gidx  = sel;
        end
      end
    end else begin
      // Walk from the farthest offset back to ptr so the nearest valid channel wins.
      for (int i = N - 1; i >= 0; i--) begin
        s = int'(ptr) + i;
        if (s >= N) s = s - N;
        cand = SELW'(s);
        if (in_valid[cand]) begin
          found = 1'b1;
          gidx  = cand;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    gdata = '0;
    for (int k = 0; k < N; k++) begin
      grant[k] = found && (gidx == SELW'(k));
      if (grant[k]) gdata = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign space    = !out_valid || out_ready;
  assign in_ready = rst ? '0 : (grant & {N{space}});
  assign xfer     = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_src   <= gidx;
      // Explicit wrap so non-power-of-two N never lets ptr reach N.
      ptr       <= (gidx == SELW'(N - 1)) ? '0 : gidx + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
